led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/sly_pkg.sv | 23 ++
 rtl/seq_fifo.sv | 58 +++++
 rtl/led_sequencer.sv | 155 +++++++++++++++
 tb/tb_led_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sly_pkg.sv
// Shared types for the LED sequencer and the button-poll logic:
// the 2-bit color code, its four named values, and the playback states.
package sly_pkg;

    typedef logic [1:0] color_t;

    localparam color_t COLOR_RED    = 2'b00;
    localparam color_t COLOR_BLUE   = 2'b01;
    localparam color_t COLOR_GREEN  = 2'b10;
    localparam color_t COLOR_YELLOW = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10
    } state_t;

    // One-hot LED vector for a color; bit index equals the color code.
    function automatic logic [3:0] color_leds(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Color queue for the LED sequencer: DEPTH x 2-bit, power-of-2 depth.
// Pointers wrap modulo DEPTH; full/empty are derived from the level count.
// A push into a full queue is taken only when a pop happens on the same edge.
module seq_fifo
    import sly_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  color_t                   din,
    output color_t                   dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    color_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer: queues color codes and plays each one as an ON_CYCLES
// flash followed by an OFF_CYCLES dark gap, pulsing done when the queue drains.
// Optional macro LED_SEQ_OVERFLOW_EN enables the sticky overflow flag;
// without it overflow is tied low and dropped writes are silently discarded.
module led_sequencer
    import sly_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned OFF_CYCLES = 12500000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [1:0]               wr_color,
    input  logic                     clear,
    output logic                     full,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     done,
    output logic                     overflow,
    output logic                     red_led,
    output logic                     blue_led,
    output logic                     green_led,
    output logic                     yellow_led
);

    localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [3:0]      leds;
    logic [3:0]      leds_next;
    logic            done_next;
    logic            pop;
    logic            push;
    logic            empty;
    color_t          head;

    // clear wins over a same-cycle write
    assign push = wr_en && !clear;

    seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .din   (color_t'(wr_color)),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Playback state, flash/gap down-counter, LED and done registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            leds  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            leds  <= leds_next;
            done  <= done_next;
        end
    end

    // Next-state logic: pop on IDLE or at gap end, time the flash and the gap.
    always_comb begin
        state_next = state;
        count_next = count;
        leds_next  = leds;
        done_next  = 1'b0;
        pop        = 1'b0;
        if (clear) begin
            state_next = IDLE;
            count_next = '0;
            leds_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ON;
                        count_next = ON_LOAD;
                        leds_next  = color_leds(head);
                    end
                end
                ON: begin
                    if (count == '0) begin
                        state_next = GAP;
                        count_next = OFF_LOAD;
                        leds_next  = '0;
                    end else begin
                        count_next = count - CW'(1);
                    end
                end
                GAP: begin
                    if (count == '0) begin
                        if (!empty) begin
                            pop        = 1'b1;
                            state_next = ON;
                            count_next = ON_LOAD;
                            leds_next  = color_leds(head);
                        end else begin
                            state_next = IDLE;
                            count_next = '0;
                            done_next  = 1'b1;
                        end
                    end else begin
                        count_next = count - CW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                    leds_next  = '0;
                end
            endcase
        end
    end

`ifdef LED_SEQ_OVERFLOW_EN
    logic drop;
    assign drop = wr_en && !clear && full && !pop;

    // Sticky record of a write lost to a full queue; cleared by reset or clear.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

    assign busy       = (state != IDLE) || !empty;
    assign red_led    = leds[COLOR_RED];
    assign blue_led   = leds[COLOR_BLUE];
    assign green_led  = leds[COLOR_GREEN];
    assign yellow_led = leds[COLOR_YELLOW];

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (DEPTH=4, ON_CYCLES=4, OFF_CYCLES=2).
// Vector tables drive writes and give per-edge expectations; a negedge
// monitor pops expected colors from a scoreboard queue at each flash start
// and checks flash length and inter-flash gap length.
module tb_led_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ON    = 4;
    localparam int unsigned OFF   = 2;
`ifdef LED_SEQ_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_color = 2'b00;
    logic       clear = 1'b0;
    logic       full, busy, done, overflow;
    logic [2:0] level;
    logic       red_led, blue_led, green_led, yellow_led;

    led_sequencer #(
        .DEPTH      (DEPTH),
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_color   (wr_color),
        .clear      (clear),
        .full       (full),
        .busy       (busy),
        .level      (level),
        .done       (done),
        .overflow   (overflow),
        .red_led    (red_led),
        .blue_led   (blue_led),
        .green_led  (green_led),
        .yellow_led (yellow_led)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       wr;
        logic [1:0] col;
        logic       acc;
        int         lvl;
        logic       full;
        logic       busy;
        logic       done;
        logic [3:0] leds;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];

    // monitor state
    logic       mon_en     = 1'b0;
    logic [3:0] prev_lit   = 4'b0;
    logic       in_seq     = 1'b0;
    int         lit_len    = 0;
    int         dark_len   = 0;
    int         done_count = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0] led_vec();
        return {yellow_led, green_led, blue_led, red_led};
    endfunction

    // Flash scoreboard: color at flash start, ON length at flash end, OFF gap between flashes.
    always @(negedge clock) begin
        logic [3:0] lit;
        logic [1:0] c;
        if (mon_en) begin
            lit = led_vec();
            if (lit != 4'b0 && prev_lit == 4'b0) begin
                check("led_onehot", $countones(lit), 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_flash", 1, 0);
                end else begin
                    c = exp_q.pop_front();
                    check("flash_color", lit, 4'b0001 << c);
                end
                if (in_seq) check("gap_len", dark_len, OFF);
                in_seq  = 1'b1;
                lit_len = 1;
            end else if (lit != 4'b0) begin
                lit_len++;
            end else if (prev_lit != 4'b0) begin
                check("on_len", lit_len, ON);
                dark_len = 1;
            end else begin
                dark_len++;
            end
            if (done) begin
                done_count++;
                in_seq = 1'b0;
            end
            prev_lit = lit;
        end
    end

    task automatic apply_vec(input vec_t v, input string tag);
        wr_en    = v.wr;
        wr_color = v.col;
        if (v.wr && v.acc) exp_q.push_back(v.col);
        @(negedge clock);
        check({tag, "_level"}, level, v.lvl);
        check({tag, "_full"}, full, v.full);
        check({tag, "_busy"}, busy, v.busy);
        check({tag, "_done"}, done, v.done);
        check({tag, "_leds"}, led_vec(), v.leds);
    endtask

    task automatic drain(input string tag, input int d0);
        wr_en = 1'b0;
        for (int t = 0; t < 200 && busy; t++) @(negedge clock);
        check({tag, "_drain_busy"}, busy, 0);
        @(negedge clock);
        check({tag, "_done_count"}, done_count - d0, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic act = 1'b0;
        for (int t = 0; t < cycles; t++) begin
            @(negedge clock);
            act = act | (led_vec() != 4'b0) | done | busy | (level != 3'd0);
        end
        check({tag, "_quiet"}, act, 0);
    endtask

    vec_t single_v[9];
    vec_t fill_v[6];

    initial begin
        int d0;
        //              wr    col    acc   lvl full  busy  done  leds
        single_v[0] = '{1'b1, 2'b01, 1'b1, 1, 1'b0, 1'b1, 1'b0, 4'b0000};
        single_v[1] = '{1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4'b0010};
        single_v[2] = '{1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4'b0010};
        single_v[3] = '{1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4'b0010};
        single_v[4] = '{1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4'b0010};
        single_v[5] = '{1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4'b0000};
        single_v[6] = '{1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 4'b0000};
        single_v[7] = '{1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b1, 4'b0000};
        single_v[8] = '{1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0, 1'b0, 4'b0000};

        fill_v[0]   = '{1'b1, 2'b00, 1'b1, 1, 1'b0, 1'b1, 1'b0, 4'b0000};
        fill_v[1]   = '{1'b1, 2'b00, 1'b1, 1, 1'b0, 1'b1, 1'b0, 4'b0001};
        fill_v[2]   = '{1'b1, 2'b10, 1'b1, 2, 1'b0, 1'b1, 1'b0, 4'b0001};
        fill_v[3]   = '{1'b1, 2'b11, 1'b1, 3, 1'b0, 1'b1, 1'b0, 4'b0001};
        fill_v[4]   = '{1'b1, 2'b01, 1'b1, 4, 1'b1, 1'b1, 1'b0, 4'b0001};
        fill_v[5]   = '{1'b1, 2'b10, 1'b0, 4, 1'b1, 1'b1, 1'b0, 4'b0000};

        // Reset with a write held active: everything zero, write ignored.
        reset = 1'b0; wr_en = 1'b1; wr_color = 2'b11;
        repeat (3) @(negedge clock);
        check("rst_leds", led_vec(), 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1; wr_en = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_write_ignored", level, 0);
        mon_en = 1'b1;

        // Single blue flash, cycle-exact.
        d0 = done_count;
        foreach (single_v[i]) apply_vec(single_v[i], "single");
        check("single_done_count", done_count - d0, 1);
        check("single_queue_empty", exp_q.size(), 0);

        // Red, yellow, red back to back.
        d0 = done_count;
        foreach (fill_v[i]) if (i < 3) begin
            wr_en = 1'b1; wr_color = (i == 1) ? 2'b11 : 2'b00;
            exp_q.push_back(wr_color);
            @(negedge clock);
        end
        drain("seq3", d0);

        // Six writes into a depth-4 queue: sixth dropped.
        d0 = done_count;
        foreach (fill_v[i]) begin
            apply_vec(fill_v[i], "fill");
            if (i == 4) check("fill_ovf_before", overflow, 0);
        end
        check("fill_overflow", overflow, OVF_EN);
        drain("fill", d0);
        check("fill_overflow_sticky", overflow, OVF_EN);

        // clear during the second flash, with a same-cycle write.
        mon_en = 1'b0;
        exp_q.delete();
        wr_en = 1'b1; wr_color = 2'b00; @(negedge clock);
        wr_color = 2'b01;               @(negedge clock);
        wr_en = 1'b0;
        for (int t = 0; t < 60 && !blue_led; t++) @(negedge clock);
        check("clr_blue_seen", blue_led, 1);
        clear = 1'b1; wr_en = 1'b1; wr_color = 2'b10;
        @(negedge clock);
        clear = 1'b0; wr_en = 1'b0;
        check("clr_leds", led_vec(), 0);
        check("clr_level", level, 0);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_overflow", overflow, 0);
        quiet("clr", 12);

        // Reset mid-GAP with three entries queued.
        foreach (fill_v[i]) if (i < 4) begin
            wr_en = 1'b1; wr_color = 2'(i); @(negedge clock);
        end
        wr_en = 1'b0;
        check("rstgap_level", level, 3);
        for (int t = 0; t < 40 && !red_led; t++) @(negedge clock);
        check("rstgap_red_on", red_led, 1);
        for (int t = 0; t < 40 && red_led; t++) @(negedge clock);
        check("rstgap_red_off", red_led, 0);
        check("rstgap_busy", busy, 1);
        check("rstgap_level3", level, 3);
        reset = 1'b0; wr_en = 1'b1; wr_color = 2'b01;
        @(negedge clock);
        check("rstgap_leds", led_vec(), 0);
        check("rstgap_level0", level, 0);
        check("rstgap_full", full, 0);
        check("rstgap_busy0", busy, 0);
        check("rstgap_done", done, 0);
        check("rstgap_overflow", overflow, 0);
        reset = 1'b1; wr_en = 1'b0;
        quiet("rstgap", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
